// File: rtl/keypad_move_decoder.sv
// Scans a 4x4 active-low keypad, debounces presses/releases and turns column keys into game moves.
// Define KEYPAD_POP_EN to enable pop arming with key A; otherwise pop_armed and move_pop stay 0.
module keypad_move_decoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] kp_row,
  output logic [3:0] kp_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] move_col,
  output logic       move_pop,
  output logic       move_valid,
  output logic       pop_armed
);

  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        row_s1_q, row_s2_q;
  logic [1:0]        col_idx_q, col_idx_d;
  logic [1:0]        col_d1_q, col_d2_q;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [3:0]        row_latch_q, row_latch_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              row_one;
  logic [1:0]        row_sel;
  logic              sample_fresh;
  logic              is_move;

  function automatic logic [3:0] key_lookup(input logic [1:0] col, input logic [1:0] row);
    case ({row, col})
      4'h0: key_lookup = 4'h1;
      4'h1: key_lookup = 4'h2;
      4'h2: key_lookup = 4'h3;
      4'h3: key_lookup = 4'hA;
      4'h4: key_lookup = 4'h4;
      4'h5: key_lookup = 4'h5;
      4'h6: key_lookup = 4'h6;
      4'h7: key_lookup = 4'hB;
      4'h8: key_lookup = 4'h7;
      4'h9: key_lookup = 4'h8;
      4'hA: key_lookup = 4'h9;
      4'hB: key_lookup = 4'hC;
      4'hC: key_lookup = 4'h0;
      4'hD: key_lookup = 4'hF;
      4'hE: key_lookup = 4'hE;
      default: key_lookup = 4'hD;
    endcase
  endfunction

  // The synchronized rows lag the column drive by two cycles, so every sample is
  // attributed to the column that was driven two cycles earlier (col_d2_q).
  always_ff @(posedge clk) begin
    if (reset) begin
      row_s1_q    <= 4'hF;
      row_s2_q    <= 4'hF;
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      col_d1_q    <= 2'd0;
      col_d2_q    <= 2'd0;
      row_idx_q   <= 2'd0;
      row_latch_q <= 4'hF;
      scan_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'h0;
    end else begin
      row_s1_q    <= kp_row;
      row_s2_q    <= row_s1_q;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      col_d1_q    <= col_idx_q;
      col_d2_q    <= col_d1_q;
      row_idx_q   <= row_idx_d;
      row_latch_q <= row_latch_d;
      scan_cnt_q  <= scan_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
    end
  end

  always_comb begin
    row_one = 1'b1;
    row_sel = 2'd0;
    case (row_s2_q)
      4'b1110: row_sel = 2'd0;
      4'b1101: row_sel = 2'd1;
      4'b1011: row_sel = 2'd2;
      4'b0111: row_sel = 2'd3;
      default: row_one = 1'b0;
    endcase
  end

  assign sample_fresh = (col_d2_q == col_idx_q);
  assign is_move      = (key_code_q >= 4'h1) && (key_code_q <= 4'h7);

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    row_idx_d   = row_idx_q;
    row_latch_d = row_latch_q;
    scan_cnt_d  = scan_cnt_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    case (state_q)
      SCAN: begin
        if (row_one) begin
          state_d     = DEBOUNCE;
          col_idx_d   = col_d2_q;
          row_idx_d   = row_sel;
          row_latch_d = row_s2_q;
          scan_cnt_d  = '0;
          deb_cnt_d   = '0;
        end else if (scan_cnt_q >= SCAN_LAST) begin
          scan_cnt_d = '0;
          col_idx_d  = col_idx_q + 2'd1;
        end else begin
          scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
      end
      DEBOUNCE: begin
        // Samples still in flight from a previously driven column are neither counted nor rejected.
        if (sample_fresh) begin
          if (row_s2_q != row_latch_q) begin
            state_d   = SCAN;
            deb_cnt_d = '0;
          end else if (deb_cnt_q >= DEB_LAST) begin
            state_d    = PRESSED;
            deb_cnt_d  = '0;
            key_code_d = key_lookup(col_idx_q, row_idx_q);
          end else begin
            deb_cnt_d = deb_cnt_q + DEB_W'(1);
          end
        end
      end
      PRESSED: begin
        state_d   = RELEASE;
        deb_cnt_d = '0;
      end
      RELEASE: begin
        if (row_s2_q != 4'hF) begin
          deb_cnt_d = '0;
        end else if (deb_cnt_q >= DEB_LAST) begin
          state_d    = SCAN;
          deb_cnt_d  = '0;
          scan_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_W'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

`ifdef KEYPAD_POP_EN
  logic pop_armed_q, pop_armed_d;

  always_ff @(posedge clk) begin
    if (reset) pop_armed_q <= 1'b0;
    else       pop_armed_q <= pop_armed_d;
  end

  always_comb begin
    pop_armed_d = pop_armed_q;
    if (state_q == PRESSED) begin
      if (is_move)                  pop_armed_d = 1'b0;
      else if (key_code_q == 4'hA)  pop_armed_d = ~pop_armed_q;
    end
  end

  assign pop_armed = pop_armed_q;
  assign move_pop  = move_valid & pop_armed_q;
`else
  assign pop_armed = 1'b0;
  assign move_pop  = 1'b0;
`endif

  assign kp_col     = ~(4'b0001 << col_idx_q);
  assign key_code   = key_code_q;
  assign key_valid  = (state_q == PRESSED);
  assign move_valid = key_valid & is_move;
  assign move_col   = move_valid ? (key_code_q - 4'd1) : 4'hF;

endmodule

// File: tb/tb_keypad_move_decoder.sv
// Scoreboard bench for keypad_move_decoder: a keypad matrix model, directed key presses, and a monitor
// that checks every key_valid pulse against the queued expectation.
module tb_keypad_move_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] kp_row;
  logic [3:0] kp_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] move_col;
  logic       move_pop;
  logic       move_valid;
  logic       pop_armed;

  logic [15:0] pressed;   // index = col*4 + row

  int total = 0;
  int bad   = 0;
  int pulses = 0;

`ifdef KEYPAD_POP_EN
  localparam logic POP = 1'b1;
`else
  localparam logic POP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] code;
    logic       mv;
    logic [3:0] mcol;
    logic       pop;
  } exp_t;

  typedef struct {
    int   col;
    int   row;
    exp_t e;
    logic arm_after;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  keypad_move_decoder #(.SCAN_DIV(2), .DEBOUNCE_CNT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .kp_row     (kp_row),
    .kp_col     (kp_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .move_col   (move_col),
    .move_pop   (move_pop),
    .move_valid (move_valid),
    .pop_armed  (pop_armed)
  );

  always #5 clk = ~clk;

  always_comb begin
    kp_row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4 + r] && !kp_col[c]) kp_row[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s got=%0h need=%0h t=%0t", name, got, need, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input int col, input int row, input logic [3:0] code, input logic mv,
                         input logic [3:0] mcol, input logic pop, input logic arm);
    vec_t v;
    v.col = col; v.row = row;
    v.e.code = code; v.e.mv = mv; v.e.mcol = mcol; v.e.pop = pop;
    v.arm_after = arm;
    vecs.push_back(v);
  endtask

  // Monitor: every pulse is matched against the oldest expectation; idle cycles must show the idle move outputs.
  always @(negedge clk) begin
    exp_t e;
    if (key_valid) begin
      pulses++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse_code", {28'd0, key_code}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("key_code", {28'd0, key_code}, {28'd0, e.code});
        chk("move_valid", {31'd0, move_valid}, {31'd0, e.mv});
        chk("move_col", {28'd0, move_col}, {28'd0, e.mcol});
        chk("move_pop", {31'd0, move_pop}, {31'd0, e.pop});
        $display("pulse key_code=%h move_valid=%b move_col=%h move_pop=%b", key_code, move_valid, move_col, move_pop);
      end
    end else begin
      chk("idle_move", {26'd0, move_valid, move_pop, move_col}, {26'd0, 2'b00, 4'hF});
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_kp_col"}, {28'd0, kp_col}, 32'hE);
    chk({tag, "_key_code"}, {28'd0, key_code}, 32'h0);
    chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'h0);
    chk({tag, "_move_col"}, {28'd0, move_col}, 32'hF);
    chk({tag, "_move_pop"}, {31'd0, move_pop}, 32'h0);
    chk({tag, "_move_valid"}, {31'd0, move_valid}, 32'h0);
    chk({tag, "_pop_armed"}, {31'd0, pop_armed}, 32'h0);
  endtask

  initial begin
    int   p0;
    logic found;

    reset   = 1'b1;
    pressed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    //       col row code  mv mcol  pop  arm_after
    add_vec(2, 0, 4'h3, 1, 4'h2, 0,   0);
    add_vec(3, 0, 4'hA, 0, 4'hF, 0,   POP);
    add_vec(1, 1, 4'h5, 1, 4'h4, POP, 0);
    add_vec(1, 0, 4'h2, 1, 4'h1, 0,   0);
    add_vec(0, 2, 4'h7, 1, 4'h6, 0,   0);
    add_vec(1, 2, 4'h8, 0, 4'hF, 0,   0);
    add_vec(0, 3, 4'h0, 0, 4'hF, 0,   0);
    add_vec(3, 3, 4'hD, 0, 4'hF, 0,   0);
    add_vec(3, 0, 4'hA, 0, 4'hF, 0,   POP);
    add_vec(3, 1, 4'hB, 0, 4'hF, 0,   POP);
    add_vec(2, 1, 4'h6, 1, 4'h5, POP, 0);
    add_vec(3, 0, 4'hA, 0, 4'hF, 0,   POP);
    add_vec(3, 0, 4'hA, 0, 4'hF, 0,   0);
    add_vec(0, 0, 4'h1, 1, 4'h0, 0,   0);

    foreach (vecs[i]) begin
      $display("press key=%h col=%0d row=%0d", vecs[i].e.code, vecs[i].col, vecs[i].row);
      sb.push_back(vecs[i].e);
      pressed[vecs[i].col*4 + vecs[i].row] = 1'b1;
      step(40);
      pressed = '0;
      step(30);
      chk("drain", sb.size(), 0);
      chk("pop_armed", {31'd0, pop_armed}, {31'd0, vecs[i].arm_after});
    end

    // Bouncing key 1: never stable long enough to be accepted.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed[0] = ~pressed[0];
      step(2);
    end
    pressed = '0;
    step(30);
    chk("bounce_pulses", pulses - p0, 0);
    $display("bounce key 1 pulses=%0d", pulses - p0);

    // Keys 1 and 4 together share column 0: ignored until 4 is released.
    p0 = pulses;
    pressed[0] = 1'b1;
    pressed[1] = 1'b1;
    step(40);
    chk("two_keys_pulses", pulses - p0, 0);
    sb.push_back('{code: 4'h1, mv: 1'b1, mcol: 4'h0, pop: 1'b0});
    pressed[1] = 1'b0;
    step(40);
    pressed = '0;
    step(30);
    chk("two_keys_drain", sb.size(), 0);
    $display("two keys then release 4 pulses=%0d", pulses - p0);

    // Reset in the middle of debouncing key 7.
    p0 = pulses;
    pressed[2] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (kp_col == 4'b1110) found = 1'b1;
    end
    chk("col0_seen", {31'd0, found}, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    reset   = 1'b1;
    pressed = '0;
    @(posedge clk);
    @(negedge clk);
    check_reset_values("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    step(40);
    chk("midreset_pulses", pulses - p0, 0);
    $display("reset during debounce of key 7 pulses=%0d", pulses - p0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_move_decoder.md
KEYPAD_MOVE_DECODER -- requirements
Module: keypad_move_decoder

Interface
REQ-001 Parameter SCAN_DIV, default 1000; clk cycles each keypad column is driven while scanning.
REQ-002 Parameter DEBOUNCE_CNT, default 50000; number of consecutive identical samples needed to accept a press or a release.
REQ-003 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 kp_row  input  4  keypad row sense lines, active-low, asynchronous to clk.
REQ-006 kp_col  output  4  keypad column drive, active-low, one-hot-low while scanning.
REQ-007 key_code  output  4  hex label of the last accepted key; held until the next accepted key.
REQ-008 key_valid  output  1  one-cycle pulse when a key press is accepted.
REQ-009 move_col  output  4  board column 0-6 during a move pulse; 4'hF at all other times.
REQ-010 move_pop  output  1  high only together with move_valid when the move is a pop.
REQ-011 move_valid  output  1  one-cycle move strobe to the game-logic stage.
REQ-012 pop_armed  output  1  level output; high while the next column key will be issued as a pop.

Function
REQ-013 kp_row SHALL pass through a 2-flop synchronizer; all logic uses only the synchronized value.
REQ-014 Key map by [column][row]: row0 = 1 2 3 A; row1 = 4 5 6 B; row2 = 7 8 9 C; row3 = 0 F E D; key_code is the hex value of the label.
REQ-015 FSM states: SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-016 SCAN: drive one column low; every SCAN_DIV cycles advance the column 0->1->2->3->0 (wrap).
REQ-017 SCAN->DEBOUNCE when exactly one synchronized row is low; freeze the column; latch that row.
REQ-018 SCAN: zero or 2+ rows low means no press; scanning continues.
REQ-019 DEBOUNCE: counter increments while the row pattern equals the latched pattern; any mismatch returns to SCAN with the counter cleared.
REQ-020 DEBOUNCE->PRESSED when the counter reaches DEBOUNCE_CNT-1.
REQ-021 PRESSED lasts exactly one cycle; key_code updated and key_valid=1 in that cycle; the next state is RELEASE.
REQ-022 RELEASE: column stays frozen; the counter counts consecutive all-high samples and clears on any low row; after DEBOUNCE_CNT the state goes to SCAN. A held key never repeats.
REQ-023 Keys 1-7 in PRESSED: move_col = key-1, move_valid=1, move_pop=pop_armed, all for that cycle only; pop_armed clears on the same edge.
REQ-024 Key A in PRESSED toggles pop_armed; no move pulse.
REQ-025 Other keys produce only key_valid; pop_armed is unchanged.
REQ-026 Outside the move pulse: move_col=4'hF, move_valid=0, move_pop=0.
REQ-027 Latency: key stable at the pins to the key_valid/move_valid pulse is 2 (sync) + DEBOUNCE_CNT + 1 cycles, plus up to 4*SCAN_DIV of scan wait.
REQ-028 Counter widths SHALL hold DEBOUNCE_CNT and SCAN_DIV without overflow; counters saturate and do not wrap.

Reset
REQ-029 Reset wins over all other activity, including mid-debounce or mid-release; the FSM returns to SCAN at column 0.
REQ-030 Reset values: kp_col=4'b1110, key_code=0, key_valid=0, move_col=4'hF, move_pop=0, move_valid=0, pop_armed=0, counters=0, synchronizer flops=4'hF.

Configuration
REQ-031 Macro KEYPAD_POP_EN defined: pop arming behaves as in REQ-023/024.
REQ-032 KEYPAD_POP_EN undefined: pop_armed and move_pop are constant 0 and key A is treated as a plain key (REQ-025).

Verification (DEBOUNCE_CNT=4, SCAN_DIV=2)
REQ-033 Hold key 3 stable -> exactly one key_valid with key_code=3 and one move_valid with move_col=2, move_pop=0; move_col is 4'hF otherwise.
REQ-034 Key A, release, then key 5 -> pop_armed goes 1 after A; the move pulse has move_col=4, move_pop=1; pop_armed then reads 0.
REQ-035 Key 1 toggling every 2 cycles for 20 cycles -> no key_valid pulse.
REQ-036 Keys 1 and 4 held together (same column, two rows low) -> no pulse; release 4 -> one move_col=0 pulse.
REQ-037 Reset asserted in the 2nd DEBOUNCE cycle of key 7 -> no pulse; outputs at reset values; kp_col=4'b1110 the next cycle.
REQ-038 KEYPAD_POP_EN undefined, key A then key 2 -> key_valid with key_code=A, then move_col=1 with move_pop=0.
